// File: rtl/board_link_frontend.sv
// Board-pin front-end between FPGA pads and the cosim core.
// Synchronises rx pads, loopback switches and the reset request pin,
// debounces the reset request, sequences the core reset release,
// registers tx pads (with per-channel loopback) and stretches rx/tx
// activity into LED-visible pulses.
module board_link_frontend #(
  parameter int CHANNELS        = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int LED_HOLD_CYCLES = 2_500_000
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                rst_req_n_i,
  input  logic [CHANNELS-1:0] loopback_i,
  input  logic [CHANNELS-1:0] rx_pad_i,
  output logic [CHANNELS-1:0] rx_o,
  input  logic [CHANNELS-1:0] tx_i,
  output logic [CHANNELS-1:0] tx_pad_o,
  output logic                core_arstn_o,
  output logic                run_led_o,
  output logic [CHANNELS-1:0] rx_led_o,
  output logic [CHANNELS-1:0] tx_led_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int LED_W  = $clog2(LED_HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [LED_W-1:0]  LED_LOAD  = LED_W'(LED_HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t            state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [SYNC_STAGES-1:0] req_sync;
  logic              req_s;
  logic              db_rel;
  logic [DB_W-1:0]   db_cnt;
  logic              run;

  assign req_s = req_sync[SYNC_STAGES-1];
  assign run   = (state == ST_RUN);

  // Reset request synchroniser (idles released/high).
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) req_sync <= '1;
    else        req_sync <= {req_sync[SYNC_STAGES-2:0], rst_req_n_i};
  end

  // Debounce: db_rel follows req_s only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      db_rel <= 1'b1;
      db_cnt <= '0;
    end else if (req_s != db_rel) begin
      if (db_cnt == DB_LAST) begin
        db_rel <= ~db_rel;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Reset sequencer state register; core reset and run LED registered from next state.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state        <= ST_ASSERT;
      hold_cnt     <= '0;
      core_arstn_o <= 1'b0;
      run_led_o    <= 1'b0;
    end else begin
      state        <= state_n;
      hold_cnt     <= hold_n;
      core_arstn_o <= (state_n == ST_RUN);
      run_led_o    <= (state_n == ST_RUN);
    end
  end

  // Reset sequencer next-state logic.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    case (state)
      ST_ASSERT: begin
        if (db_rel) begin
          state_n = ST_HOLD;
          hold_n  = '0;
        end
      end
      ST_HOLD: begin
        if (!db_rel)                   state_n = ST_ASSERT;
        else if (hold_cnt == HOLD_LAST) state_n = ST_RUN;
        else                           hold_n  = hold_cnt + 1'b1;
      end
      ST_RUN: begin
        if (!db_rel) state_n = ST_ASSERT;
      end
      default: state_n = ST_ASSERT;
    endcase
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] rx_sync;
    logic [SYNC_STAGES-1:0] lb_sync;
    logic                   rx_s;
    logic                   lb;
    logic                   tx_pad_q;
    logic                   rx_prev;
    logic                   tx_prev;
    logic [LED_W-1:0]       rx_cnt;
    logic [LED_W-1:0]       tx_cnt;

    assign rx_s        = rx_sync[SYNC_STAGES-1];
    assign lb          = lb_sync[SYNC_STAGES-1];
    assign rx_o[c]     = rx_s;
    assign tx_pad_o[c] = tx_pad_q;
    assign rx_led_o[c] = (rx_cnt != '0);
    assign tx_led_o[c] = (tx_cnt != '0);

    // rx pad and loopback switch synchronisers.
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        rx_sync <= '1;
        lb_sync <= '0;
      end else begin
        rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_pad_i[c]};
        lb_sync <= {lb_sync[SYNC_STAGES-2:0], loopback_i[c]};
      end
    end

    // tx pad register: loopback overrides, otherwise idle high unless the core runs.
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i)  tx_pad_q <= 1'b1;
      else if (lb) tx_pad_q <= rx_s;
      else         tx_pad_q <= run ? tx_i[c] : 1'b1;
    end

    // Activity stretchers: a falling edge (re)loads the counter, otherwise it drains.
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        rx_prev <= 1'b1;
        tx_prev <= 1'b1;
        rx_cnt  <= '0;
        tx_cnt  <= '0;
      end else begin
        rx_prev <= rx_s;
        tx_prev <= tx_i[c];
        if (rx_prev && !rx_s)         rx_cnt <= LED_LOAD;
        else if (rx_cnt != '0)        rx_cnt <= rx_cnt - 1'b1;
        if (tx_prev && !tx_i[c] && run) tx_cnt <= LED_LOAD;
        else if (tx_cnt != '0)        tx_cnt <= tx_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_link_frontend.sv
// Randomised bench for board_link_frontend against a behavioural model
// built from delay queues, run lengths and LED ages.
module tb_board_link_frontend;

  localparam int CH = 2;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RH = 5;
  localparam int LH = 8;

  logic          clk = 1'b0;
  logic          arst;
  logic          rst_req_n;
  logic [CH-1:0] loopback;
  logic [CH-1:0] rx_pad;
  logic [CH-1:0] rx;
  logic [CH-1:0] tx;
  logic [CH-1:0] tx_pad;
  logic          core_arstn;
  logic          run_led;
  logic [CH-1:0] rx_led;
  logic [CH-1:0] tx_led;

  always #5 clk = ~clk;

  board_link_frontend #(
    .CHANNELS(CH),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DB),
    .RST_HOLD_CYCLES(RH),
    .LED_HOLD_CYCLES(LH)
  ) dut (
    .clk_i(clk),
    .arst_i(arst),
    .rst_req_n_i(rst_req_n),
    .loopback_i(loopback),
    .rx_pad_i(rx_pad),
    .rx_o(rx),
    .tx_i(tx),
    .tx_pad_o(tx_pad),
    .core_arstn_o(core_arstn),
    .run_led_o(run_led),
    .rx_led_o(rx_led),
    .tx_led_o(tx_led)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [CH-1:0] q_rx[$];
  logic [CH-1:0] q_lb[$];
  logic          q_req[$];
  logic [CH-1:0] m_rx, m_rx_prev, m_lb, m_txpad, m_tx_prev;
  logic          m_req, m_db, m_run;
  int            diff_len, rel_len;
  int            rx_age[CH];
  int            tx_age[CH];

  task automatic model_reset();
    q_rx = {}; q_lb = {}; q_req = {};
    for (int i = 0; i < SS - 1; i++) begin
      q_rx.push_back('1);
      q_lb.push_back('0);
      q_req.push_back(1'b1);
    end
    m_rx = '1; m_rx_prev = '1; m_lb = '0; m_txpad = '1; m_tx_prev = '1;
    m_req = 1'b1; m_db = 1'b1; m_run = 1'b0;
    diff_len = 0; rel_len = 0;
    for (int c = 0; c < CH; c++) begin
      rx_age[c] = LH;
      tx_age[c] = LH;
    end
  endtask

  // One clock edge of the model; all decisions use pre-edge values.
  task automatic model_step();
    logic [CH-1:0] o_rx, o_rx_prev, o_lb;
    logic          o_req, o_db, o_run;
    o_rx = m_rx; o_rx_prev = m_rx_prev; o_lb = m_lb;
    o_req = m_req; o_db = m_db; o_run = m_run;
    for (int c = 0; c < CH; c++) begin
      m_txpad[c] = o_lb[c] ? o_rx[c] : (o_run ? tx[c] : 1'b1);
      if (o_rx_prev[c] && !o_rx[c]) rx_age[c] = 0;
      else if (rx_age[c] < LH)      rx_age[c]++;
      if (m_tx_prev[c] && !tx[c] && o_run) tx_age[c] = 0;
      else if (tx_age[c] < LH)             tx_age[c]++;
    end
    m_tx_prev = tx;
    q_rx.push_back(rx_pad);     m_rx  = q_rx.pop_front(); m_rx_prev = o_rx;
    q_lb.push_back(loopback);   m_lb  = q_lb.pop_front();
    q_req.push_back(rst_req_n); m_req = q_req.pop_front();
    if (o_req != o_db) begin
      diff_len++;
      if (diff_len == DB) begin
        m_db = ~o_db;
        diff_len = 0;
      end
    end else begin
      diff_len = 0;
    end
    if (o_db) begin
      if (rel_len < RH + 1) rel_len++;
    end else begin
      rel_len = 0;
    end
    m_run = (rel_len >= RH + 1);
  endtask

  task automatic compare_all();
    logic [CH-1:0] e_rxl, e_txl;
    for (int c = 0; c < CH; c++) begin
      e_rxl[c] = (rx_age[c] < LH);
      e_txl[c] = (tx_age[c] < LH);
    end
    check_eq("rx_o", 32'(rx), 32'(m_rx));
    check_eq("tx_pad", 32'(tx_pad), 32'(m_txpad));
    check_eq("core_arstn", 32'(core_arstn), 32'(m_run));
    check_eq("run_led", 32'(run_led), 32'(m_run));
    check_eq("rx_led", 32'(rx_led), 32'(e_rxl));
    check_eq("tx_led", 32'(tx_led), 32'(e_txl));
  endtask

  int seg_left = 0;
  logic seg_val = 1'b1;
  int arst_left = 0;

  initial begin
    arst = 1'b1; rst_req_n = 1'b1; loopback = '0; rx_pad = '1; tx = '1;
    model_reset();
    #12;
    check_eq("rst_core", 32'(core_arstn), 32'd0);
    check_eq("rst_txpad", 32'(tx_pad), 32'h3);
    compare_all();
    @(negedge clk);
    arst = 1'b0;

    // Release sequence with the pin released: core up from edge RH+1.
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_eq("rel_seq", 32'(core_arstn), 32'(k >= RH + 1));
      compare_all();
    end

    for (int cyc = 0; cyc < 5000; cyc++) begin
      // Inputs change on the falling edge.
      if (seg_left == 0) begin
        seg_val  = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
        seg_left = seg_val ? $urandom_range(1, 16) : $urandom_range(1, 8);
      end
      rst_req_n = seg_val;
      seg_left--;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 99) < 12) rx_pad[c]   = ~rx_pad[c];
        if ($urandom_range(0, 99) < 25) tx[c]       = ~tx[c];
        if ($urandom_range(0, 99) < 2)  loopback[c] = ~loopback[c];
      end
      if (arst_left > 0) begin
        arst_left--;
        if (arst_left == 0) arst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        arst = 1'b1;
        arst_left = $urandom_range(1, 3);
        model_reset();
        #1;
        check_eq("arst_core", 32'(core_arstn), 32'd0);
        check_eq("arst_leds", 32'({rx_led, tx_led, run_led}), 32'd0);
        check_eq("arst_txpad", 32'(tx_pad), 32'h3);
      end
      @(posedge clk);
      if (arst) model_reset();
      else      model_step();
      @(negedge clk);
      compare_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_link_frontend.md
Name: board_link_frontend

Overview:
- Parametrised board-pin front-end between FPGA pads and the cosim core. Generalises the single-link, single-reset pin hookup to CHANNELS UART links.
- Synchronises rx pads and loopback switches. Debounces the raw reset request and sequences the core reset release.
- Registers tx pads with per-channel loopback mode and stretches rx/tx activity into LED-visible pulses.

Parameters:
- CHANNELS, 1, number of independent UART links.
- SYNC_STAGES, 2, synchroniser depth for every asynchronous input (>=2).
- DEBOUNCE_CYCLES, 500_000, consecutive stable cycles before the debounced reset request changes (10 ms at 50 MHz; >=1).
- RST_HOLD_CYCLES, 16, cycles the core reset is held low after the request is released (>=1).
- LED_HOLD_CYCLES, 2_500_000, LED on-time after activity (50 ms at 50 MHz; >=1).

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  asynchronous, active-high reset.
- rst_req_n_i  in  1  raw reset request pin, active low, asynchronous, bouncy.
- loopback_i  in  CHANNELS  raw per-channel loopback switches, asynchronous.
- rx_pad_i  in  CHANNELS  raw UART rx pads, idle high.
- rx_o  out  CHANNELS  synchronised rx to core.
- tx_i  in  CHANNELS  core UART tx.
- tx_pad_o  out  CHANNELS  registered tx pads.
- core_arstn_o  out  1  core reset, active low.
- run_led_o  out  1  high while core is out of reset.
- rx_led_o  out  CHANNELS  stretched rx activity.
- tx_led_o  out  CHANNELS  stretched tx activity.

Behaviour:
- Reset values:
  - rx sync chains, rx_o, tx_pad_o: all 1.
  - loopback sync: 0. rst_req sync chain: 1. Debounced request (db_rel): 1, meaning released.
  - Debounce counter: 0. FSM: ASSERT. core_arstn_o: 0. run_led_o: 0. LED counters and LEDs: 0.
  - core_arstn_o goes low asynchronously on arst_i and is released only synchronously.
- Synchronisers: SYNC_STAGES flops per bit. rx_o = last stage, latency SYNC_STAGES edges. lb[c] = synchronised loopback_i[c].
- Debounce:
  - cnt increments while the synchronised request differs from db_rel; it clears whenever they agree.
  - When cnt reaches DEBOUNCE_CYCLES-1 and the inputs still differ, db_rel toggles and cnt clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves db_rel unchanged.
- Reset FSM (registered; core_arstn_o and run_led_o are registered and equal 1 exactly when state==RUN):
  - ASSERT: if db_rel=1, go to HOLD with hold_cnt=0.
  - HOLD: if db_rel=0, go to ASSERT. Otherwise, if hold_cnt==RST_HOLD_CYCLES-1, go to RUN; else hold_cnt+1.
  - RUN: if db_rel=0, go to ASSERT. core_arstn_o drops at the same edge.
  - After arst_i release with the pin released, core_arstn_o rises at edge 1+RST_HOLD_CYCLES.
- tx path, 1-cycle registered:
  - tx_pad_o[c] <= lb[c] ? rx_o[c] : (state==RUN ? tx_i[c] : 1).
  - Loopback works regardless of core reset state. A loopback toggle takes effect on the edge after lb changes.
- LEDs, per channel:
  - Falling edge of rx_o[c] (previous 1, current 0) loads rx counter = LED_HOLD_CYCLES. Otherwise a nonzero counter decrements.
  - rx_led_o[c] = counter != 0.
  - A falling edge while counting reloads the counter (retrigger, no accumulation).
  - tx LEDs work the same on falling edges of tx_i[c], counted only when state==RUN.
- Counter widths are $clog2(N+1); wrap-around is impossible by construction.
- Simultaneous events:
  - arst_i overrides everything.
  - A db_rel fall in HOLD on the final count goes to ASSERT, not RUN.
- Reset mid-operation: all counters, LEDs and tx pads return to their reset values immediately.

Test Plan:
- Common parameters: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=5, LED_HOLD_CYCLES=8.
- Release arst_i with rst_req_n_i=1 -> core_arstn_o=0 for 5 edges, 1 from edge 6; run_led_o matches.
- In RUN, drive rst_req_n_i=0 steadily -> core_arstn_o falls at edge 7 after the pin change (2 sync + 4 debounce + 1). Release the pin -> core_arstn_o returns high 2+4+1+5 edges later.
- In RUN, pulse rst_req_n_i=0 for 3 cycles -> db_rel stays 1 and core_arstn_o stays 1. A 4-cycle stable pulse -> reset asserts.
- rx_pad_i[1] falls in RUN -> rx_o[1] falls after 2 edges. rx_led_o[1] is high for exactly 8 cycles. A second fall at count 3 retriggers to 8 more cycles. rx_led_o[0] stays 0.
- loopback_i[0]=1, toggle rx_pad_i[0] -> tx_pad_o[0] follows 3 edges later, including during ASSERT. With loopback_i[0]=0 in ASSERT -> tx_pad_o[0]=1 regardless of tx_i[0].
- Assert arst_i mid-HOLD and mid-LED-stretch -> core_arstn_o, LEDs and run_led_o go 0 and tx_pad_o goes 1 immediately. On release, the full hold sequence restarts.
